// File: rtl/ss_comparator.sv
// Signal-strength comparator with compare/subtract modes and a tick-gated
// scheduled update of DELAY game ticks.
module ss_comparator #(
    parameter int unsigned SS_W    = 4,
    parameter int unsigned DELAY   = 1,
    parameter int unsigned INIT_SS = 0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_tick,
    input  logic            i_mode,
    input  logic [SS_W-1:0] i_rear,
    input  logic [SS_W-1:0] i_side_a,
    input  logic [SS_W-1:0] i_side_b,
    output logic [SS_W-1:0] o_ss,
    output logic            o_pwr,
    output logic            o_busy,
    output logic            o_changed
);

    localparam int unsigned      CNT_W    = $clog2(DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [SS_W-1:0]  SS_INIT  = SS_W'(INIT_SS);

    // Reject illegal parameterisations at elaboration.
    generate
        if (DELAY < 1) begin : g_bad_delay
            $error("ss_comparator: DELAY must be >= 1");
        end
        if (64'(INIT_SS) >= (64'd1 << SS_W)) begin : g_bad_init
            $error("ss_comparator: INIT_SS must fit in SS_W bits");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [SS_W-1:0]  ss_n;
    logic             changed_n;
    logic [SS_W-1:0]  side;
    logic [SS_W-1:0]  target;

    // Target strength: strongest side input gates (compare) or reduces (subtract) the rear.
    always_comb begin
        side   = (i_side_a >= i_side_b) ? i_side_a : i_side_b;
        target = '0;
        if (i_mode) begin
            if (i_rear > side) begin
                target = i_rear - side;
            end
        end else if (i_rear >= side) begin
            target = i_rear;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            o_ss      <= SS_INIT;
            o_changed <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            o_ss      <= ss_n;
            o_changed <= changed_n;
        end
    end

    // Next-state: expiry samples the target on the expiry tick itself, not the trigger tick.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ss_n      = o_ss;
        changed_n = 1'b0;
        if (i_tick) begin
            case (state)
                ST_IDLE: begin
                    if (target != o_ss) begin
                        if (DELAY == 1) begin
                            ss_n      = target;
                            changed_n = 1'b1;
                        end else begin
                            cnt_n   = CNT_LOAD;
                            state_n = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt > CNT_ONE) begin
                        cnt_n = cnt - CNT_ONE;
                    end else begin
                        ss_n      = target;
                        changed_n = (target != o_ss);
                        cnt_n     = '0;
                        state_n   = ST_IDLE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign o_pwr  = |o_ss;
    assign o_busy = (state == ST_WAIT);

endmodule

// File: tb/tb_ss_comparator.sv
// Bench for ss_comparator: three instances (DELAY 1/3/4) share stimulus and are
// checked against a tick-numbered scheduling model plus directed expectations.
module tb_ss_comparator;

    localparam int unsigned SS_W = 4;
    localparam int NI = 3;
    localparam int DLY  [NI] = '{1, 3, 4};
    localparam int INIT [NI] = '{5, 0, 5};

    logic            clk = 1'b0;
    logic            rst_n;
    logic            tick;
    logic            mode;
    logic [SS_W-1:0] rear;
    logic [SS_W-1:0] side_a;
    logic [SS_W-1:0] side_b;

    logic [NI-1:0][SS_W-1:0] ss;
    logic [NI-1:0]           pwr;
    logic [NI-1:0]           busy;
    logic [NI-1:0]           chg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ss_comparator #(.SS_W(4), .DELAY(1), .INIT_SS(5)) u_d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_mode(mode),
        .i_rear(rear), .i_side_a(side_a), .i_side_b(side_b),
        .o_ss(ss[0]), .o_pwr(pwr[0]), .o_busy(busy[0]), .o_changed(chg[0])
    );
    ss_comparator #(.SS_W(4), .DELAY(3), .INIT_SS(0)) u_d3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_mode(mode),
        .i_rear(rear), .i_side_a(side_a), .i_side_b(side_b),
        .o_ss(ss[1]), .o_pwr(pwr[1]), .o_busy(busy[1]), .o_changed(chg[1])
    );
    ss_comparator #(.SS_W(4), .DELAY(4), .INIT_SS(5)) u_d4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_mode(mode),
        .i_rear(rear), .i_side_a(side_a), .i_side_b(side_b),
        .o_ss(ss[2]), .o_pwr(pwr[2]), .o_busy(busy[2]), .o_changed(chg[2])
    );

    // Reference: an update becomes due at tick number (trigger + DELAY - 1).
    function automatic logic [SS_W-1:0] ref_target(input logic md, input int r, input int a, input int b);
        int s;
        s = (a > b) ? a : b;
        if (md) return (r > s) ? SS_W'(r - s) : '0;
        return (r >= s) ? SS_W'(r) : '0;
    endfunction

    logic [NI-1:0][SS_W-1:0] m_ss;
    logic [NI-1:0]           m_pend;
    logic [NI-1:0]           m_chg;
    int                      m_due [NI];
    int                      tcount;
    logic [SS_W-1:0]         tgt;

    always_comb tgt = ref_target(mode, int'(rear), int'(side_a), int'(side_b));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                m_ss[k]   <= SS_W'(INIT[k]);
                m_pend[k] <= 1'b0;
                m_chg[k]  <= 1'b0;
                m_due[k]  <= 0;
            end
            tcount <= 0;
        end else begin
            if (tick) tcount <= tcount + 1;
            for (int k = 0; k < NI; k++) begin
                m_chg[k] <= 1'b0;
                if (tick) begin
                    if (!m_pend[k]) begin
                        if (tgt != m_ss[k]) begin
                            if (DLY[k] == 1) begin
                                m_ss[k]  <= tgt;
                                m_chg[k] <= 1'b1;
                            end else begin
                                m_pend[k] <= 1'b1;
                                m_due[k]  <= tcount + DLY[k];
                            end
                        end
                    end else if (tcount + 1 == m_due[k]) begin
                        m_pend[k] <= 1'b0;
                        if (tgt != m_ss[k]) begin
                            m_ss[k]  <= tgt;
                            m_chg[k] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic step(input logic t);
        tick = t;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        mode = 1'b0; rear = '0; side_a = '0; side_b = '0;
        for (int i = 0; i < 6; i++) step(1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mode = 1'($urandom); rear = SS_W'($urandom);
            side_a = SS_W'($urandom); side_b = SS_W'($urandom);
            step(1'($urandom));
            n_checks++;
            if (ss[0] !== 4'd5 || ss[2] !== 4'd5 || ss[1] !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_ss i=%0d got %0d/%0d/%0d expected 5/0/5", i, ss[0], ss[1], ss[2]);
            end
            n_checks++;
            if (pwr !== 3'b101 || busy !== 3'b000 || chg !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_flags i=%0d got pwr=%b busy=%b chg=%b expected 101/000/000", i, pwr, busy, chg);
            end
        end
        rst_n = 1'b1;
        step(1'b0);
        n_checks++;
        if (busy !== 3'b000 || ss[0] !== 4'd5) begin
            n_fail++;
            $display("FAIL reset_release got busy=%b ss0=%0d expected 000/5", busy, ss[0]);
        end
    endtask

    task automatic test_compare_d1();
        logic [SS_W-1:0] exp_ss;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin mode = 1'b0; rear = 4'd9; side_a = 4'd4; side_b = 4'd7; end
            if (i == 1) side_b = 4'd12;
            if (i >= 2) rear = 4'd15;
            step(i < 2);
            exp_ss = (i == 0) ? 4'd9 : 4'd0;
            n_checks++;
            if (ss[0] !== exp_ss || chg[0] !== (i < 2)) begin
                n_fail++;
                $display("FAIL compare_d1 i=%0d got ss=%0d chg=%b expected ss=%0d chg=%b", i, ss[0], chg[0], exp_ss, (i < 2));
            end
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if ({ss[k], busy[k], chg[k], pwr[k]} !== {m_ss[k], m_pend[k], m_chg[k], |m_ss[k]}) begin
                    n_fail++;
                    $display("FAIL compare_model dut%0d got ss=%0d busy=%b chg=%b pwr=%b expected ss=%0d busy=%b chg=%b",
                             k, ss[k], busy[k], chg[k], pwr[k], m_ss[k], m_pend[k], m_chg[k]);
                end
            end
        end
    endtask

    task automatic test_subtract_d1();
        logic [SS_W-1:0] exp_tab [3] = '{4'd2, 4'd0, 4'd15};
        for (int i = 0; i < 6; i++) begin
            mode = 1'b1;
            if (i == 0) begin rear = 4'd9; side_a = 4'd4; side_b = 4'd7; end
            if (i == 2) rear = 4'd3;
            if (i == 4) begin rear = 4'd15; side_a = 4'd0; side_b = 4'd0; end
            step(i % 2 == 0);
            n_checks++;
            if (ss[0] !== exp_tab[i/2] || chg[0] !== (i % 2 == 0)) begin
                n_fail++;
                $display("FAIL subtract_d1 i=%0d got ss=%0d chg=%b expected ss=%0d chg=%b", i, ss[0], chg[0], exp_tab[i/2], (i % 2 == 0));
            end
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if ({ss[k], busy[k], chg[k], pwr[k]} !== {m_ss[k], m_pend[k], m_chg[k], |m_ss[k]}) begin
                    n_fail++;
                    $display("FAIL subtract_model dut%0d got ss=%0d busy=%b chg=%b pwr=%b expected ss=%0d busy=%b chg=%b",
                             k, ss[k], busy[k], chg[k], pwr[k], m_ss[k], m_pend[k], m_chg[k]);
                end
            end
        end
    endtask

    task automatic test_delay3();
        logic [SS_W-1:0] exp_ss;
        settle();
        rear = 4'd10;
        for (int c = 0; c < 12; c++) begin
            step(c % 4 == 0);
            exp_ss = (c >= 8) ? 4'd10 : 4'd0;
            n_checks++;
            if (ss[1] !== exp_ss || busy[1] !== (c < 8) || chg[1] !== (c == 8)) begin
                n_fail++;
                $display("FAIL delay3 c=%0d got ss=%0d busy=%b chg=%b expected ss=%0d busy=%b chg=%b",
                         c, ss[1], busy[1], chg[1], exp_ss, (c < 8), (c == 8));
            end
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if ({ss[k], busy[k], chg[k], pwr[k]} !== {m_ss[k], m_pend[k], m_chg[k], |m_ss[k]}) begin
                    n_fail++;
                    $display("FAIL delay3_model dut%0d got ss=%0d busy=%b chg=%b pwr=%b expected ss=%0d busy=%b chg=%b",
                             k, ss[k], busy[k], chg[k], pwr[k], m_ss[k], m_pend[k], m_chg[k]);
                end
            end
        end
    endtask

    task automatic test_short_pulse();
        logic [SS_W-1:0] exp_ss;
        for (int v = 0; v < 2; v++) begin
            settle();
            for (int c = 0; c < 3; c++) begin
                rear = (c == 0) ? 4'd10 : ((c == 2 && v == 1) ? 4'd6 : 4'd0);
                step(1'b1);
                exp_ss = (c == 2 && v == 1) ? 4'd6 : 4'd0;
                n_checks++;
                if (ss[1] !== exp_ss || busy[1] !== (c < 2) || chg[1] !== (c == 2 && v == 1)) begin
                    n_fail++;
                    $display("FAIL short_pulse v=%0d c=%0d got ss=%0d busy=%b chg=%b expected ss=%0d busy=%b chg=%b",
                             v, c, ss[1], busy[1], chg[1], exp_ss, (c < 2), (c == 2 && v == 1));
                end
                for (int k = 0; k < NI; k++) begin
                    n_checks++;
                    if ({ss[k], busy[k], chg[k], pwr[k]} !== {m_ss[k], m_pend[k], m_chg[k], |m_ss[k]}) begin
                        n_fail++;
                        $display("FAIL pulse_model dut%0d got ss=%0d busy=%b chg=%b pwr=%b expected ss=%0d busy=%b chg=%b",
                                 k, ss[k], busy[k], chg[k], pwr[k], m_ss[k], m_pend[k], m_chg[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        settle();
        rear = 4'd9;
        step(1'b1);
        step(1'b1);
        n_checks++;
        if (busy[2] !== 1'b1 || ss[2] !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_wait_pre got busy=%b ss=%0d expected 1/0", busy[2], ss[2]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ss[2] !== 4'd5 || busy[2] !== 1'b0 || pwr[2] !== 1'b1 || ss[0] !== 4'd5 || ss[1] !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_wait_async got ss=%0d/%0d/%0d busy4=%b pwr4=%b expected 5/0/5 0 1",
                     ss[0], ss[1], ss[2], busy[2], pwr[2]);
        end
        step(1'b1);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(1'b1);
            n_checks++;
            if (ss[2] !== ((c >= 3) ? 4'd9 : 4'd5) || busy[2] !== (c < 3) || chg[2] !== (c == 3)) begin
                n_fail++;
                $display("FAIL mid_wait_restart c=%0d got ss=%0d busy=%b chg=%b expected ss=%0d busy=%b chg=%b",
                         c, ss[2], busy[2], chg[2], (c >= 3) ? 9 : 5, (c < 3), (c == 3));
            end
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if ({ss[k], busy[k], chg[k], pwr[k]} !== {m_ss[k], m_pend[k], m_chg[k], |m_ss[k]}) begin
                    n_fail++;
                    $display("FAIL mid_wait_model dut%0d got ss=%0d busy=%b chg=%b pwr=%b expected ss=%0d busy=%b chg=%b",
                             k, ss[k], busy[k], chg[k], pwr[k], m_ss[k], m_pend[k], m_chg[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0)  rear   = SS_W'($urandom);
            if ($urandom_range(7) == 0)  side_a = SS_W'($urandom);
            if ($urandom_range(7) == 0)  side_b = SS_W'($urandom);
            if ($urandom_range(15) == 0) mode   = ~mode;
            rst_n = ($urandom_range(149) != 0);
            step($urandom_range(2) != 0);
            rst_n = 1'b1;
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if ({ss[k], busy[k], chg[k], pwr[k]} !== {m_ss[k], m_pend[k], m_chg[k], |m_ss[k]}) begin
                    n_fail++;
                    $display("FAIL random_model i=%0d dut%0d got ss=%0d busy=%b chg=%b pwr=%b expected ss=%0d busy=%b chg=%b",
                             i, k, ss[k], busy[k], chg[k], pwr[k], m_ss[k], m_pend[k], m_chg[k]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; mode = 1'b0;
        rear = '0; side_a = '0; side_b = '0;
        test_reset();
        test_compare_d1();
        test_subtract_d1();
        test_delay3();
        test_short_pulse();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ss_comparator.md
Name: ss_comparator

Overview:
- Parametrised signal-strength comparator for the redstone fabric; successor to the single-bit, fixed-one-tick comparator buffer.
- Carries multi-bit signal strength (SS_W bits) and supports runtime compare/subtract mode and two side inputs.
- Adds a programmable scheduled-update delay (DELAY game ticks) gated by a game-tick strobe.
- Sits between the world-simulation netlist and downstream repeaters, torches and comparators; o_pwr feeds single-bit consumers.

Parameters:
SS_W, 4, signal-strength width; the maximum strength is 2^SS_W-1.
DELAY, 1, scheduled-update delay in game ticks; must be ≥1 (elaboration error otherwise).
INIT_SS, 0, output strength loaded at reset; must be < 2^SS_W.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_tick  in  1  game-tick strobe; all state changes occur only on clock edges where i_tick=1
i_mode  in  1  0 = compare, 1 = subtract
i_rear  in  SS_W  rear input strength
i_side_a  in  SS_W  side input A strength
i_side_b  in  SS_W  side input B strength
o_ss  out  SS_W  registered output strength
o_pwr  out  1  |o_ss (combinational from the register)
o_busy  out  1  high while an update is pending (state WAIT)
o_changed  out  1  one-cycle pulse on the edge after o_ss takes a new value

Behaviour:
- Clock and reset: one clock, i_clk; reset is asynchronous, active-low on i_rst_n.
- Reset values:
  - o_ss=INIT_SS, o_pwr=|INIT_SS, o_busy=0, o_changed=0.
  - State IDLE, countdown=0.
  - Asserting reset mid-WAIT cancels the pending update; no late write occurs after release.
- Combinational target (recomputed every cycle):
  - side = max(i_side_a, i_side_b).
  - Compare mode: target = (i_rear >= side) ? i_rear : 0.
  - Subtract mode: target = (i_rear > side) ? i_rear - side : 0.
  - No wrap-around; all arithmetic stays within SS_W bits.
- Edges with i_tick=0: no state change; o_changed returns to 0.
- State machine, DELAY=1:
  - On each tick with target != o_ss: o_ss <= target.
  - o_busy is always 0.
  - This is cycle-equivalent to a plain registered comparator sampled on ticks.
- State machine, DELAY>1, state IDLE:
  - On a tick with target != o_ss: countdown <= DELAY-1, go to WAIT.
  - On a tick with target == o_ss: stay in IDLE.
- State machine, DELAY>1, state WAIT:
  - On a tick with countdown > 1: countdown decrements.
  - On a tick with countdown == 1: o_ss <= target sampled on that tick (not the triggering tick), then go to IDLE.
  - If target == o_ss at expiry, o_ss is unchanged, o_changed stays 0, and the block goes to IDLE.
- Latency: o_ss updates on the DELAY-th tick counted from the triggering tick (the triggering tick counts as 1).
- Input changes during WAIT, including an i_mode change, do not restart or extend the countdown.
- A pulse shorter than DELAY ticks that reverts before expiry produces no output change.
- An input change on the same tick as expiry is captured by that expiry.
- A mismatch that remains after returning to IDLE is detected on the next tick, not the expiry tick; there is no back-to-back chaining.
- o_busy = (state == WAIT).
- o_changed = 1 for exactly one cycle, the cycle after the edge on which o_ss changed.
- Countdown width is $clog2(DELAY+1).

Test Plan:
- Reset: INIT_SS=5, hold i_rst_n=0, toggle inputs and tick → o_ss=5, o_pwr=1, o_busy=0 throughout; release reset → IDLE.
- Compare, DELAY=1: rear=9, sides 4/7 on tick → o_ss=9 after 1 tick. Then side_b=12 → o_ss=0 after the next tick. With i_tick=0 for 10 cycles o_ss holds.
- Subtract, DELAY=1: rear=9, sides 4/7 → o_ss=2. rear=3 → o_ss=0 (saturation). rear=15, sides 0/0 → 15. Each change gives a single o_changed pulse.
- DELAY=3: rear 0→10 on tick T → o_busy=1 on T and T+1. o_ss=10 and o_busy=0 after tick T+2. Ticks spaced 4 clocks apart: o_ss holds between ticks.
- DELAY=3 short pulse: rear=10 on tick T, rear=0 from T+1 → no o_ss change, no o_changed. Rear changed to 6 at T+2 → o_ss=6 after T+2.
- Reset mid-WAIT with DELAY=4: assert i_rst_n=0 two ticks into WAIT → o_ss=INIT_SS immediately (asynchronous), o_busy=0. After release with the same inputs, a fresh 4-tick countdown runs.
